// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall controller.
// Contents:
//   state_e          - sequencer state (RUN / MULDIV)
//   *_DEF            - default parameter values for the controller
//   REG_ZERO         - architectural register 0 (hard-wired zero, never a hazard)
package pipe_ctrl_pkg;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_MULDIV = 1'b1
   } state_e;

   localparam int MULDIV_LAT_DEF  = 32;
   localparam int CNT_W_DEF       = 6;
   localparam int STALL_CNT_W_DEF = 16;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard detector.
// A load in EX whose destination is a source of the instruction in ID
// cannot forward in time, so one bubble is needed. Register 0 never hazards.
// Ports:
//   idex_memread_i  in  1  instruction in EX is a load
//   idex_rt_i       in  5  load destination register
//   ifid_rs_i       in  5  rs of instruction in ID
//   ifid_rt_i       in  5  rt of instruction in ID
//   load_use_o      out 1  stall request
module load_use_detector
   import pipe_ctrl_pkg::*;
(
   input  logic       idex_memread_i,
   input  logic [4:0] idex_rt_i,
   input  logic [4:0] ifid_rs_i,
   input  logic [4:0] ifid_rt_i,
   output logic       load_use_o
);

   assign load_use_o = idex_memread_i
                       && (idex_rt_i != REG_ZERO)
                       && ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Resolves data-memory wait, multi-cycle mul/div, taken branch and load-use
// hazards (in that priority) into stage write-enables, bubbles and flushes.
// Ports:
//   clk_i, rst_n_i                  clock (rising edge), async active-low reset
//   IDEX_MemRead, IDEX_RegisterRt   load in EX and its destination
//   IFID_RegisterRs/Rt              sources of instruction in ID
//   branch_taken_i                  branch in EX resolved taken
//   muldiv_start_i                  mul/div in EX
//   mem_req_i, mem_ready_i          MEM access and its completion
//   PC_Write .. EXMEM_Write         stage write-enables (1 = advance)
//   Control_select, EXMEM_Bubble    zero control into ID/EX resp. EX/MEM
//   IFID_Flush                      clear IF/ID to nop
//   busy_o                          FSM is in MULDIV (doubles as state debug view)
//   stall_count_o                   saturating count of cycles with PC_Write==0
// Outputs are combinational from state, counter and inputs. While rst_n_i is
// low the outputs are forced to their defaults.
// Parameter legality: MULDIV_LAT >= 2 and 2**CNT_W > MULDIV_LAT.
module pipeline_stall_controller
   import pipe_ctrl_pkg::*;
#(
   parameter int MULDIV_LAT  = MULDIV_LAT_DEF,
   parameter int CNT_W       = CNT_W_DEF,
   parameter int STALL_CNT_W = STALL_CNT_W_DEF
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   IDEX_MemRead,
   input  logic [4:0]             IDEX_RegisterRt,
   input  logic [4:0]             IFID_RegisterRs,
   input  logic [4:0]             IFID_RegisterRt,
   input  logic                   branch_taken_i,
   input  logic                   muldiv_start_i,
   input  logic                   mem_req_i,
   input  logic                   mem_ready_i,
   output logic                   PC_Write,
   output logic                   IFID_Write,
   output logic                   IDEX_Write,
   output logic                   EXMEM_Write,
   output logic                   Control_select,
   output logic                   EXMEM_Bubble,
   output logic                   IFID_Flush,
   output logic                   busy_o,
   output logic [STALL_CNT_W-1:0] stall_count_o
);

   // The start cycle is spent in RUN and the release cycle at count 0, so
   // the counter is loaded with LAT-2 to give exactly LAT cycles in EX.
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(MULDIV_LAT - 2);

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic mem_stall;
   logic load_use;

   assign mem_stall = mem_req_i & ~mem_ready_i;

   load_use_detector u_load_use_detector (
      .idex_memread_i (IDEX_MemRead),
      .idex_rt_i      (IDEX_RegisterRt),
      .ifid_rs_i      (IFID_RegisterRs),
      .ifid_rt_i      (IFID_RegisterRt),
      .load_use_o     (load_use)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= ST_RUN;
         cnt_q       <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      PC_Write       = 1'b1;
      IFID_Write     = 1'b1;
      IDEX_Write     = 1'b1;
      EXMEM_Write    = 1'b1;
      Control_select = 1'b0;
      EXMEM_Bubble   = 1'b0;
      IFID_Flush     = 1'b0;

      if (rst_n_i) begin
         unique case (state_q)
            ST_RUN: begin
               if (mem_stall) begin
                  PC_Write    = 1'b0;
                  IFID_Write  = 1'b0;
                  IDEX_Write  = 1'b0;
                  EXMEM_Write = 1'b0;
               end else if (muldiv_start_i) begin
                  PC_Write     = 1'b0;
                  IFID_Write   = 1'b0;
                  IDEX_Write   = 1'b0;
                  EXMEM_Bubble = 1'b1;
                  cnt_d        = CNT_RELOAD;
                  state_d      = ST_MULDIV;
               end else if (branch_taken_i) begin
                  // Branch beats load-use: the ID instruction is wrong-path.
                  IFID_Flush     = 1'b1;
                  Control_select = 1'b1;
               end else if (load_use) begin
                  PC_Write       = 1'b0;
                  IFID_Write     = 1'b0;
                  Control_select = 1'b1;
               end
            end
            ST_MULDIV: begin
               // Latency keeps counting through a MEM stall.
               cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
               if ((cnt_q != '0) || mem_stall) begin
                  PC_Write     = 1'b0;
                  IFID_Write   = 1'b0;
                  IDEX_Write   = 1'b0;
                  EXMEM_Write  = ~mem_stall;
                  EXMEM_Bubble = ~mem_stall;
               end else begin
                  state_d = ST_RUN;
               end
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   assign stall_cnt_d   = (!PC_Write && (stall_cnt_q != '1)) ? stall_cnt_q + STALL_CNT_W'(1)
                                                             : stall_cnt_q;
   assign stall_count_o = stall_cnt_q;
   assign busy_o        = (state_q == ST_MULDIV);

endmodule
